// File: rtl/ternary_pkg.sv
// Shared types for the ternary core hazard logic: balanced trits, register
// index mapping and the hazard controller state encoding.
package ternary_pkg;

    typedef enum logic [1:0] {
        T_ZERO = 2'b00,
        T_POS  = 2'b01,
        T_NEG  = 2'b10
    } trit_t;

    localparam int NUM_TREGS = 27;
    localparam int IDX_W     = 5;

    typedef enum logic {
        HS_RUN      = 1'b0,
        HS_MDU_BUSY = 1'b1
    } hazard_state_t;

    // Balanced value of a 3-trit address offset by 13, giving 0..26.
    // The unused 2'b11 code is treated as zero.
    function automatic logic [IDX_W-1:0] trit3_to_idx(input trit_t [2:0] a);
        int acc;
        int w;
        acc = 13;
        w   = 1;
        for (int i = 0; i < 3; i++) begin
            case (a[i])
                T_POS:   acc = acc + w;
                T_NEG:   acc = acc - w;
                default: acc = acc;
            endcase
            w = w * 3;
        end
        return IDX_W'(acc);
    endfunction

    function automatic logic is_r0(input trit_t [2:0] a);
        return (a[2] == T_ZERO) && (a[1] == T_ZERO) && (a[0] == T_ZERO);
    endfunction

endpackage

// File: rtl/ternary_scoreboard.sv
// Pending-result bitmap for MDU destinations: one set port, one clear port,
// a full clear, and three read ports (rs1, rs2, rd for WAW).
module ternary_scoreboard
    import ternary_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [IDX_W-1:0]     set_idx,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx,
    input  logic                 clr_all,
    input  logic [IDX_W-1:0]     rd1_idx,
    input  logic [IDX_W-1:0]     rd2_idx,
    input  logic [IDX_W-1:0]     rd3_idx,
    output logic                 rd1_pend,
    output logic                 rd2_pend,
    output logic                 rd3_pend,
    output logic [NUM_TREGS-1:0] pending
);

    logic [NUM_TREGS-1:0] pend_reg;

    // Set is checked first so it wins over a clear of the same entry.
    for (genvar gi = 0; gi < NUM_TREGS; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_reg[gi] <= 1'b0;
            end else if (set_en && (set_idx == IDX_W'(gi))) begin
                pend_reg[gi] <= 1'b1;
            end else if (clr_all || (clr_en && (clr_idx == IDX_W'(gi)))) begin
                pend_reg[gi] <= 1'b0;
            end
        end
    end

    assign rd1_pend = pend_reg[rd1_idx];
    assign rd2_pend = pend_reg[rd2_idx];
    assign rd3_pend = pend_reg[rd3_idx];
    assign pending  = pend_reg;

endmodule

// File: rtl/ternary_hazard_ctrl.sv
// ID-stage hazard/stall controller: load-use, MDU scoreboard RAW/WAW and
// branch flush, plus MDU issue sequencing with a timeout watchdog.
module ternary_hazard_ctrl
    import ternary_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  trit_t [2:0]          id_rs1,
    input  trit_t [2:0]          id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  trit_t [2:0]          id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_is_mdu,
    input  logic                 ex_valid,
    input  trit_t [2:0]          ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mdu_done,
    input  trit_t [2:0]          mdu_done_rd,
    output logic                 mdu_start,
    output trit_t [2:0]          mdu_rd,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic [NUM_TREGS-1:0] sb_pending,
    output logic [CNT_W-1:0]     stall_count,
    output logic                 mdu_timeout_err
);

    localparam int TMR_W = 10;

    hazard_state_t      state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               mdu_start_reg;
    trit_t [2:0]        mdu_rd_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic rs1_pend, rs2_pend, rd_pend;
    logic lu_haz, sb_haz, mb_haz, haz, issue;
    logic sb_set_en, sb_clr_en, sb_clr_all, err_set;

    ternary_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set_en),
        .set_idx  (trit3_to_idx(id_rd)),
        .clr_en   (sb_clr_en),
        .clr_idx  (trit3_to_idx(mdu_done_rd)),
        .clr_all  (sb_clr_all),
        .rd1_idx  (trit3_to_idx(id_rs1)),
        .rd2_idx  (trit3_to_idx(id_rs2)),
        .rd3_idx  (trit3_to_idx(id_rd)),
        .rd1_pend (rs1_pend),
        .rd2_pend (rs2_pend),
        .rd3_pend (rd_pend),
        .pending  (sb_pending)
    );

    assign lu_haz = ex_valid && ex_mem_read && !is_r0(ex_rd) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign sb_haz = id_valid && ((id_uses_rs1 && rs1_pend) ||
                                 (id_uses_rs2 && rs2_pend) ||
                                 (id_reg_write && rd_pend));
    assign mb_haz = id_valid && id_is_mdu && (state_reg == HS_MDU_BUSY);
    assign haz    = lu_haz || sb_haz || mb_haz;
    assign issue  = id_valid && id_is_mdu && !haz && !ex_branch_taken &&
                    (state_reg == HS_RUN);

    // R0 is never tracked, so a write to it must not set its entry.
    assign sb_set_en = issue && id_reg_write && !is_r0(id_rd);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        sb_clr_en  = 1'b0;
        sb_clr_all = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            HS_RUN: begin
                timer_next = '0;
                if (issue) state_next = HS_MDU_BUSY;
            end
            HS_MDU_BUSY: begin
                if (mdu_done) begin
                    state_next = HS_RUN;
                    sb_clr_en  = 1'b1;
                    timer_next = '0;
                end else if (timer_reg == TMR_W'(MDU_TIMEOUT - 1)) begin
                    state_next = HS_RUN;
                    sb_clr_all = 1'b1;
                    err_set    = 1'b1;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = HS_RUN;
        endcase
    end

    // A taken branch overrides any stall: the ID instruction is wrong-path.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (haz) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HS_RUN;
            timer_reg     <= '0;
            mdu_start_reg <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            for (int i = 0; i < 3; i++) mdu_rd_reg[i] <= T_ZERO;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            mdu_start_reg <= issue;
            err_reg       <= err_reg || err_set;
            if (issue) mdu_rd_reg <= id_rd;
            if (stall_id && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign mdu_start       = mdu_start_reg;
    assign mdu_rd          = mdu_rd_reg;
    assign stall_count     = cnt_reg;
    assign mdu_timeout_err = err_reg;

endmodule

// File: tb/tb_ternary_hazard_ctrl.sv
// Self-checking bench for ternary_hazard_ctrl: integer-address reference model,
// a vector table, directed multi-cycle sequences and randomized traffic.
module tb_ternary_hazard_ctrl;
    import ternary_pkg::*;

    localparam int TO   = 8;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_mdu;
    trit_t [2:0] id_rs1, id_rs2, id_rd, ex_rd, mdu_done_rd, mdu_rd;
    logic ex_valid, ex_mem_read, ex_branch_taken, mdu_done;
    logic mdu_start, stall_if, stall_id, flush_id, flush_ex, mdu_timeout_err;
    logic [26:0] sb_pending;
    logic [CW-1:0] stall_count;

    ternary_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_mdu(id_is_mdu),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd),
        .mdu_start(mdu_start), .mdu_rd(mdu_rd),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .sb_pending(sb_pending), .stall_count(stall_count),
        .mdu_timeout_err(mdu_timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Stimulus expressed as integer register addresses in -13..13.
    bit i_idv, i_u1, i_u2, i_rw, i_mdu, i_exv, i_exmr, i_br, i_done;
    int i_rs1, i_rs2, i_rd, i_exrd, i_done_rd;

    // Reference model state.
    bit pend_m [-13:13];
    bit busy_m, err_m, start_m;
    int timer_m, cnt_m, mdu_rd_m;

    typedef struct {
        bit exv; bit exmr; int exrd; bit br;
        bit idv; bit u1; int rs1; bit u2; int rs2; int rd; bit rw; bit mdu;
        bit e_stall; bit e_fid; bit e_fex;
    } vec_t;
    vec_t tbl [10];

    function automatic trit_t [2:0] to_trits(input int v);
        trit_t [2:0] t;
        int x;
        int r;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r = ((x % 3) + 3) % 3;
            if (r == 1) begin
                t[i] = T_POS;  x = (x - 1) / 3;
            end else if (r == 2) begin
                t[i] = T_NEG;  x = (x + 1) / 3;
            end else begin
                t[i] = T_ZERO; x = x / 3;
            end
        end
        return t;
    endfunction

    function automatic logic [26:0] pend_bits();
        logic [26:0] b;
        for (int v = -13; v <= 13; v++) b[v + 13] = pend_m[v];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        i_idv = 0; i_u1 = 0; i_u2 = 0; i_rw = 0; i_mdu = 0;
        i_exv = 0; i_exmr = 0; i_br = 0; i_done = 0;
        i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_exrd = 0; i_done_rd = 0;
    endtask

    task automatic drive();
        id_valid = i_idv; id_uses_rs1 = i_u1; id_uses_rs2 = i_u2;
        id_reg_write = i_rw; id_is_mdu = i_mdu;
        id_rs1 = to_trits(i_rs1); id_rs2 = to_trits(i_rs2); id_rd = to_trits(i_rd);
        ex_valid = i_exv; ex_mem_read = i_exmr; ex_rd = to_trits(i_exrd);
        ex_branch_taken = i_br;
        mdu_done = i_done; mdu_done_rd = to_trits(i_done_rd);
    endtask

    task automatic model_reset();
        for (int v = -13; v <= 13; v++) pend_m[v] = 0;
        busy_m = 0; err_m = 0; start_m = 0; timer_m = 0; cnt_m = 0; mdu_rd_m = 0;
    endtask

    // Evaluate one cycle at the falling edge: compare, then advance the model.
    task automatic run();
        bit lu, sb, mb, haz, st, issue;
        trit_t [2:0] exp_rd;
        drive();
        @(negedge clk);
        lu = i_exv && i_exmr && (i_exrd != 0) && i_idv &&
             ((i_u1 && i_rs1 == i_exrd) || (i_u2 && i_rs2 == i_exrd));
        sb = i_idv && ((i_u1 && pend_m[i_rs1]) || (i_u2 && pend_m[i_rs2]) ||
                       (i_rw && pend_m[i_rd]));
        mb = i_idv && i_mdu && busy_m;
        haz = lu || sb || mb;
        st = haz && !i_br;
        issue = i_idv && i_mdu && !haz && !i_br && !busy_m;
        exp_rd = to_trits(mdu_rd_m);
        check("stall_if", 32'(stall_if), 32'(st));
        check("stall_id", 32'(stall_id), 32'(st));
        check("flush_id", 32'(flush_id), 32'(i_br));
        check("flush_ex", 32'(flush_ex), 32'(i_br || haz));
        check("mdu_start", 32'(mdu_start), 32'(start_m));
        check("mdu_rd", 32'(mdu_rd), 32'(exp_rd));
        check("sb_pending", 32'(sb_pending), 32'(pend_bits()));
        check("stall_count", 32'(stall_count), 32'(cnt_m));
        check("timeout_err", 32'(mdu_timeout_err), 32'(err_m));
        start_m = issue;
        if (st && cnt_m < CMAX) cnt_m++;
        if (busy_m) begin
            if (i_done) begin
                pend_m[i_done_rd] = 0; busy_m = 0; timer_m = 0;
            end else if (timer_m == TO - 1) begin
                for (int v = -13; v <= 13; v++) pend_m[v] = 0;
                err_m = 1; busy_m = 0; timer_m = 0;
            end else begin
                timer_m++;
            end
        end
        if (issue) begin
            if (i_rw && i_rd != 0) pend_m[i_rd] = 1;
            mdu_rd_m = i_rd;
            busy_m = 1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        run();
        adv();
    endtask

    function automatic int rnd_addr();
        int pool [8] = '{0, 7, -7, 4, 5, -3, 13, -13};
        if ($urandom_range(2) != 0) return pool[$urandom_range(7)];
        return int'($urandom_range(26)) - 13;
    endfunction

    task automatic mdu_op(input int rd);
        idle(); i_idv = 1; i_mdu = 1; i_rd = rd; i_rw = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(); drive(); model_reset();
        #1;
        check("reset_stall", 32'(stall_id), 32'd0);
        check("reset_sb", 32'(sb_pending), 32'd0);
        check("reset_cnt", 32'(stall_count), 32'd0);
        check("reset_start", 32'(mdu_start), 32'd0);
        @(negedge clk);
        rst_n = 1;
        adv();

        // Load-use: one stall cycle, then the load has left EX.
        idle(); i_exv = 1; i_exmr = 1; i_exrd = 5; i_idv = 1; i_u1 = 1; i_rs1 = 5;
        i_rd = 1; i_rw = 1;
        run(); check("lu_stall", 32'(stall_id), 32'd1); adv();
        i_exv = 0; i_exmr = 0;
        run(); check("lu_release", 32'(stall_id), 32'd0); adv();
        idle();
        run(); check("lu_count", 32'(stall_count), 32'd1); adv();
        i_exv = 1; i_exmr = 1; i_exrd = 0; i_idv = 1; i_u1 = 1; i_rs1 = 0;
        run(); check("lu_r0", 32'(stall_id), 32'd0); adv();

        // Vector table, applied from RUN with an empty scoreboard.
        tbl[0] = '{1, 1,  5, 0, 1, 1,  5, 0,  0, 1, 1, 0, 1, 0, 1};
        tbl[1] = '{1, 1,  0, 0, 1, 1,  0, 0,  0, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 1, -4, 0, 1, 0,  0, 1, -4, 2, 1, 0, 1, 0, 1};
        tbl[3] = '{1, 1,  5, 0, 1, 0,  5, 0,  5, 2, 1, 0, 0, 0, 0};
        tbl[4] = '{1, 0,  5, 0, 1, 1,  5, 0,  0, 2, 1, 0, 0, 0, 0};
        tbl[5] = '{1, 1,  5, 0, 0, 1,  5, 0,  0, 2, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 1,  5, 1, 1, 1,  5, 0,  0, 6, 1, 1, 0, 1, 1};
        tbl[7] = '{0, 0,  0, 1, 1, 0,  0, 0,  0, 6, 1, 1, 0, 1, 1};
        tbl[8] = '{0, 1,  5, 0, 1, 1,  5, 0,  0, 2, 1, 0, 0, 0, 0};
        tbl[9] = '{1, 1,  4, 0, 1, 1,  5, 1, -5, 2, 1, 0, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            idle();
            i_exv = tbl[k].exv; i_exmr = tbl[k].exmr; i_exrd = tbl[k].exrd;
            i_br = tbl[k].br; i_idv = tbl[k].idv; i_u1 = tbl[k].u1;
            i_rs1 = tbl[k].rs1; i_u2 = tbl[k].u2; i_rs2 = tbl[k].rs2;
            i_rd = tbl[k].rd; i_rw = tbl[k].rw; i_mdu = tbl[k].mdu;
            run();
            check($sformatf("tbl%0d_stall", k), 32'(stall_id), 32'(tbl[k].e_stall));
            check($sformatf("tbl%0d_fid", k), 32'(flush_id), 32'(tbl[k].e_fid));
            check($sformatf("tbl%0d_fex", k), 32'(flush_ex), 32'(tbl[k].e_fex));
            adv();
        end
        idle();
        run(); check("br_no_issue", 32'(mdu_start), 32'd0); adv();

        // MDU issue to +7, dependent reader stalls until done.
        mdu_op(7); step();
        idle(); i_idv = 1; i_u1 = 1; i_rs1 = 7; i_rd = 2; i_rw = 1;
        run();
        check("mdu_start_pulse", 32'(mdu_start), 32'd1);
        check("sb_bit20", 32'(sb_pending[20]), 32'd1);
        check("raw_stall", 32'(stall_id), 32'd1);
        adv();
        for (int k = 0; k < 3; k++) step();
        i_done = 1; i_done_rd = 7;
        run(); check("raw_stall_done_cycle", 32'(stall_id), 32'd1); adv();
        i_done = 0;
        run();
        check("raw_release", 32'(stall_id), 32'd0);
        check("sb_bit20_clr", 32'(sb_pending[20]), 32'd0);
        adv();

        // Independent work flows while busy; a second MDU op waits.
        mdu_op(7); step();
        idle(); i_idv = 1; i_u1 = 1; i_rs1 = -3; i_u2 = 1; i_rs2 = 2; i_rd = 1; i_rw = 1;
        run(); check("indep_no_stall", 32'(stall_id), 32'd0); adv();
        mdu_op(4); i_u1 = 1; i_rs1 = 1;
        run(); check("mdu2_stall", 32'(stall_id), 32'd1); adv();
        i_done = 1; i_done_rd = 7;
        run(); check("mdu2_stall_done", 32'(stall_id), 32'd1); adv();
        i_done = 0;
        run(); check("mdu2_issue", 32'(stall_id), 32'd0); adv();
        idle();
        run();
        check("mdu2_start", 32'(mdu_start), 32'd1);
        check("sb_bit17", 32'(sb_pending[17]), 32'd1);
        adv();
        i_done = 1; i_done_rd = 4; step();
        idle(); step();

        // Watchdog: no done for TO busy cycles.
        mdu_op(4); step();
        idle();
        for (int k = 0; k < TO; k++) step();
        run();
        check("timeout_err", 32'(mdu_timeout_err), 32'd1);
        check("timeout_sb_clr", 32'(sb_pending), 32'd0);
        adv();
        for (int k = 0; k < 3; k++) step();
        run(); check("timeout_sticky", 32'(mdu_timeout_err), 32'd1); adv();
        mdu_op(2); step();
        idle();
        run(); check("post_timeout_issue", 32'(mdu_start), 32'd1); adv();
        step();

        // Asynchronous reset in the middle of MDU_BUSY.
        idle(); drive();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("areset_sb", 32'(sb_pending), 32'd0);
        check("areset_cnt", 32'(stall_count), 32'd0);
        check("areset_err", 32'(mdu_timeout_err), 32'd0);
        check("areset_start", 32'(mdu_start), 32'd0);
        check("areset_stall", 32'(stall_if), 32'd0);
        @(negedge clk);
        rst_n = 1;
        adv();
        i_done = 1; i_done_rd = 2; step();
        idle();
        run();
        check("done_after_reset_sb", 32'(sb_pending), 32'd0);
        check("done_after_reset_err", 32'(mdu_timeout_err), 32'd0);
        adv();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            i_idv = ($urandom_range(3) != 0);
            i_u1 = $urandom_range(1); i_u2 = $urandom_range(1);
            i_rw = $urandom_range(1); i_mdu = ($urandom_range(3) == 0);
            i_rs1 = rnd_addr(); i_rs2 = rnd_addr(); i_rd = rnd_addr();
            i_exv = $urandom_range(1); i_exmr = ($urandom_range(2) == 0);
            i_exrd = rnd_addr(); i_br = ($urandom_range(7) == 0);
            if (busy_m) begin
                i_done = ($urandom_range(4) == 0);
                i_done_rd = ($urandom_range(3) != 0) ? mdu_rd_m : rnd_addr();
            end else begin
                i_done = ($urandom_range(15) == 0);
                i_done_rd = rnd_addr();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
